// File: rtl/cpu_axil_bridge_pkg.sv
// Shared encodings for the CPU-to-AXI4-Lite bridge: FSM states, AXI protection codes,
// the error word, and the registered request layout.
package cpu_axil_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0]  PROT_DATA    = 3'b000;
  localparam logic [2:0]  PROT_INSTR   = 3'b100;
  localparam logic [31:0] BUS_ERR_WORD = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } cpu_req_t;

endpackage

// File: rtl/cpu_axil_bridge_if.sv
// AXI4-Lite bus between the bridge (master) and the memory controller (slave).
interface cpu_axil_bridge_if;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;

  modport master (
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata,
    input  m_axi_rready
  );
endinterface

// File: rtl/cpu_axil_bridge_timeout.sv
// Response watchdog: counts cycles while enabled; expired stays high from TIMEOUT_CYCLES-1 on
// so a handshake that wins the expiry edge still gets aborted in the following state.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt >= TIMEOUT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cpu_axil_bridge.sv
// CPU valid/ready port to AXI4-Lite master; one transaction in flight, bounded by a
// response timeout that completes the access with bus_error instead of hanging the CPU.
module cpu_axil_bridge
  import cpu_axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_error,
  cpu_axil_bridge_if.master m_axi
);
  logic [2:0] state;
  cpu_req_t   req_q;
  logic       arvalid, awvalid, wvalid, rready, bready;
  logic       aw_done, w_done, aborted;
  logic       aw_hs, w_hs, expired, active;

  assign active = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                  (state == S_WR_REQ)  || (state == S_WR_RESP);
  assign aw_hs  = awvalid && m_axi.m_axi_awready;
  assign w_hs   = wvalid  && m_axi.m_axi_wready;

  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_W(TIMEOUT_W)) u_tmo (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .clear   ((state == S_IDLE) && mem_valid),
    .enable  (active),
    .expired (expired)
  );

  // Bus fields come only from the registered request, never straight from the CPU.
  assign m_axi.m_axi_araddr  = req_q.addr;
  assign m_axi.m_axi_arprot  = req_q.instr ? PROT_INSTR : PROT_DATA;
  assign m_axi.m_axi_arvalid = arvalid;
  assign m_axi.m_axi_rready  = rready;
  assign m_axi.m_axi_awaddr  = req_q.addr;
  assign m_axi.m_axi_awprot  = PROT_DATA;
  assign m_axi.m_axi_awvalid = awvalid;
  assign m_axi.m_axi_wdata   = req_q.wdata;
  assign m_axi.m_axi_wstrb   = req_q.wstrb;
  assign m_axi.m_axi_wvalid  = wvalid;
  assign m_axi.m_axi_bready  = bready;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state     <= S_IDLE;
      req_q     <= '0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      rready    <= 1'b0;
      bready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      aborted   <= 1'b0;
      mem_ready <= 1'b0;
      bus_error <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (mem_valid) begin
          req_q   <= '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          aborted <= 1'b0;
          if (mem_wstrb == 4'b0000) begin
            arvalid <= 1'b1;
            state   <= S_RD_ADDR;
          end else begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= S_WR_REQ;
          end
        end
        S_RD_ADDR: begin
          if (m_axi.m_axi_arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RD_DATA;
          end else if (expired) begin
            arvalid   <= 1'b0;
            mem_rdata <= BUS_ERR_WORD;
            aborted   <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RD_DATA: begin
          if (m_axi.m_axi_rvalid) begin
            mem_rdata <= m_axi.m_axi_rdata;
            rready    <= 1'b0;
            state     <= S_RESP;
          end else if (expired) begin
            rready    <= 1'b0;
            mem_rdata <= BUS_ERR_WORD;
            aborted   <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin awvalid <= 1'b0; aw_done <= 1'b1; end
          if (w_hs)  begin wvalid  <= 1'b0; w_done  <= 1'b1; end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= S_WR_RESP;
          end else if (expired) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aborted <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi.m_axi_bvalid) begin
            bready <= 1'b0;
            state  <= S_RESP;
          end else if (expired) begin
            bready  <= 1'b0;
            aborted <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          mem_ready <= 1'b1;
          bus_error <= aborted;
          state     <= S_DONE;
        end
        S_DONE: begin
          // One dead cycle so the CPU's late mem_valid drop cannot start a second access.
          mem_ready <= 1'b0;
          bus_error <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Scoreboard bench for cpu_axil_bridge: a configurable AXI4-Lite slave, per-scenario tasks,
// expected CPU responses queued at issue and compared when mem_ready pulses.
module tb_cpu_axil_bridge;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        mem_valid, mem_instr, mem_ready, bus_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 CLK = ~CLK;

  cpu_axil_bridge_if axi();

  cpu_axil_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(5)) dut (
    .CLK(CLK), .RSTb(RSTb), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_error(bus_error), .m_axi(axi)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        is_rd;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // slave configuration (-1 latency = never ready) and observations
  int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0;
  logic [31:0] r_val = '0;
  logic        stray_r = 1'b0, stray_b = 1'b0;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0, stab_err = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata, aw_hold, w_hold;
  logic [2:0]  last_arprot, last_awprot;
  logic [3:0]  last_wstrb, ws_hold;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  logic        pend_r = 1'b0, aw_seen = 1'b0, w_seen = 1'b0, pend_b = 1'b0;

  initial begin
    axi.m_axi_arready = 0; axi.m_axi_awready = 0; axi.m_axi_wready = 0;
    axi.m_axi_rvalid = 0; axi.m_axi_bvalid = 0; axi.m_axi_rdata = '0;
  end

  always @(negedge CLK) begin
    if (!RSTb) begin
      axi.m_axi_arready = 0; axi.m_axi_awready = 0; axi.m_axi_wready = 0;
      axi.m_axi_rvalid = 0; axi.m_axi_bvalid = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
      pend_r = 0; aw_seen = 0; w_seen = 0; pend_b = 0;
    end else begin
      // AR: a ready still high here means the preceding posedge completed the handshake
      if (axi.m_axi_arready) begin
        ar_hs++; last_araddr = axi.m_axi_araddr; last_arprot = axi.m_axi_arprot;
        axi.m_axi_arready = 0; pend_r = 1; r_cnt = 0; ar_cnt = 0;
      end else if (axi.m_axi_arvalid) begin
        ar_cnt++;
        if (ar_lat >= 0 && ar_cnt > ar_lat) axi.m_axi_arready = 1;
      end else ar_cnt = 0;
      // R
      if (stray_r) axi.m_axi_rvalid = 1;
      else if (axi.m_axi_rvalid && !axi.m_axi_rready) begin
        axi.m_axi_rvalid = 0;
        if (pend_r) begin r_hs++; pend_r = 0; end
      end else if (pend_r && axi.m_axi_rready && !axi.m_axi_rvalid) begin
        r_cnt++;
        if (r_cnt > r_lat) begin axi.m_axi_rvalid = 1; axi.m_axi_rdata = r_val; end
      end
      // AW
      if (axi.m_axi_awready) begin
        aw_hs++; last_awaddr = axi.m_axi_awaddr; last_awprot = axi.m_axi_awprot;
        if (axi.m_axi_awaddr !== aw_hold) stab_err++;
        axi.m_axi_awready = 0; aw_seen = 1; aw_cnt = 0;
      end else if (axi.m_axi_awvalid) begin
        if (aw_cnt == 0) aw_hold = axi.m_axi_awaddr;
        else if (axi.m_axi_awaddr !== aw_hold) stab_err++;
        aw_cnt++;
        if (aw_lat >= 0 && aw_cnt > aw_lat) axi.m_axi_awready = 1;
      end else aw_cnt = 0;
      // W
      if (axi.m_axi_wready) begin
        w_hs++; last_wdata = axi.m_axi_wdata; last_wstrb = axi.m_axi_wstrb;
        if (axi.m_axi_wdata !== w_hold || axi.m_axi_wstrb !== ws_hold) stab_err++;
        axi.m_axi_wready = 0; w_seen = 1; w_cnt = 0;
      end else if (axi.m_axi_wvalid) begin
        if (w_cnt == 0) begin w_hold = axi.m_axi_wdata; ws_hold = axi.m_axi_wstrb; end
        else if (axi.m_axi_wdata !== w_hold || axi.m_axi_wstrb !== ws_hold) stab_err++;
        w_cnt++;
        if (w_lat >= 0 && w_cnt > w_lat) axi.m_axi_wready = 1;
      end else w_cnt = 0;
      // B
      if (stray_b) axi.m_axi_bvalid = 1;
      else if (axi.m_axi_bvalid && !axi.m_axi_bready) begin
        axi.m_axi_bvalid = 0;
        if (pend_b) begin b_hs++; pend_b = 0; end
      end else if (aw_seen && w_seen && axi.m_axi_bready) begin
        axi.m_axi_bvalid = 1; aw_seen = 0; w_seen = 0; pend_b = 1;
      end
    end
  end

  // Drive one CPU request, wait (bounded) for mem_ready, keep mem_valid one extra cycle.
  task automatic cpu_xfer(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                          input logic instr, output logic got, output logic [31:0] rd,
                          output logic err, output logic pulse_once);
    int n = 0;
    @(negedge CLK);
    mem_addr = addr; mem_wdata = wd; mem_wstrb = strb; mem_instr = instr; mem_valid = 1;
    while (!mem_ready && n < 100) begin @(negedge CLK); n++; end
    got = mem_ready; rd = mem_rdata; err = bus_error;
    @(negedge CLK);
    pulse_once = !mem_ready;
    mem_valid = 0;
  endtask

  task automatic test_reset;
    checks++; if (mem_ready !== 1'b0 || bus_error !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_cpu_outs: ready=%b err=%b rdata=%h, want 0/0/0", mem_ready, bus_error, mem_rdata); end
    checks++; if ({axi.m_axi_arvalid, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_rready, axi.m_axi_bready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_ctrl: ar/aw/w/r/b=%b, want 00000",
        {axi.m_axi_arvalid, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_rready, axi.m_axi_bready}); end
    checks++; if (axi.m_axi_araddr !== 32'h0 || axi.m_axi_wdata !== 32'h0 || axi.m_axi_wstrb !== 4'h0) begin
      errors++; $display("FAIL reset_axi_data: araddr=%h wdata=%h wstrb=%h, want 0", axi.m_axi_araddr, axi.m_axi_wdata, axi.m_axi_wstrb); end
  endtask

  // Issue a request with its expected response queued, then compare against the popped entry.
  task automatic run_and_check(input string nm, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, input logic instr, input logic [31:0] exp_rd,
                               input logic exp_err);
    logic got, err, once; logic [31:0] rd; exp_t e;
    exp_q.push_back('{rdata: exp_rd, is_rd: (strb == 4'h0), err: exp_err});
    cpu_xfer(addr, wd, strb, instr, got, rd, err, once);
    e = exp_q.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s_ready: no mem_ready within budget", nm); end
    else begin
      if (e.is_rd) begin
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL %s_rdata: got %h want %h", nm, rd, e.rdata); end
      end
      checks++; if (err !== e.err) begin errors++; $display("FAIL %s_bus_error: got %b want %b", nm, err, e.err); end
      checks++; if (once !== 1'b1) begin errors++; $display("FAIL %s_pulse: mem_ready not a single-cycle pulse", nm); end
    end
  endtask

  task automatic test_read_rom;
    int a0 = ar_hs;
    ar_lat = 0; r_lat = 0; r_val = 32'h1234_5678;
    run_and_check("rom", 32'h0000_0010, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0);
    checks++; if (ar_hs != a0 + 1) begin errors++; $display("FAIL rom_ar_count: got %0d want %0d", ar_hs - a0, 1); end
    checks++; if (last_araddr !== 32'h0000_0010 || last_arprot !== 3'b000) begin
      errors++; $display("FAIL rom_ar_fields: araddr=%h arprot=%b want 00000010/000", last_araddr, last_arprot); end
  endtask

  task automatic test_ifetch;
    ar_lat = 1; r_lat = 2; r_val = 32'h0000_0013;
    run_and_check("ifetch", 32'h0000_0000, 32'h0, 4'h0, 1'b1, 32'h0000_0013, 1'b0);
    checks++; if (last_arprot !== 3'b100 || last_araddr !== 32'h0) begin
      errors++; $display("FAIL ifetch_arprot: arprot=%b araddr=%h want 100/00000000", last_arprot, last_araddr); end
  endtask

  task automatic test_write_scratch;
    int a0 = ar_hs, b0 = b_hs, s0 = stab_err;
    aw_lat = 0; w_lat = 4;
    run_and_check("wr", 32'h1000_0004, 32'hCAFE_F00D, 4'b0011, 1'b0, 32'h0, 1'b0);
    checks++; if (last_awaddr !== 32'h1000_0004 || last_awprot !== 3'b000) begin
      errors++; $display("FAIL wr_aw_fields: awaddr=%h awprot=%b want 10000004/000", last_awaddr, last_awprot); end
    checks++; if (last_wdata !== 32'hCAFE_F00D || last_wstrb !== 4'b0011) begin
      errors++; $display("FAIL wr_w_fields: wdata=%h wstrb=%b want cafef00d/0011", last_wdata, last_wstrb); end
    checks++; if (stab_err != s0) begin errors++; $display("FAIL wr_stable: %0d changes while valid, want 0", stab_err - s0); end
    checks++; if (b_hs != b0 + 1 || ar_hs != a0) begin
      errors++; $display("FAIL wr_counts: b=%0d ar=%0d want 1/0", b_hs - b0, ar_hs - a0); end
  endtask

  task automatic test_w_before_aw;
    int aw0 = aw_hs, w0 = w_hs, b0 = b_hs;
    aw_lat = 2; w_lat = 0;
    run_and_check("w_first", 32'h1000_0008, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0, 1'b0);
    checks++; if (aw_hs != aw0 + 1 || w_hs != w0 + 1 || b_hs != b0 + 1) begin
      errors++; $display("FAIL w_first_counts: aw=%0d w=%0d b=%0d want 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
    checks++; if (last_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL w_first_wdata: got %h want 0badf00d", last_wdata); end
  endtask

  task automatic test_timeout;
    int r0;
    ar_lat = -1;
    run_and_check("tmo_rd", 32'h3000_0000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    checks++; if (axi.m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL tmo_arvalid: got %b want 0", axi.m_axi_arvalid); end
    // late reply after the abort must not be accepted
    r0 = r_hs;
    stray_r = 1; stray_b = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (axi.m_axi_rready !== 1'b0 || axi.m_axi_bready !== 1'b0 || mem_ready !== 1'b0) begin
        errors++; $display("FAIL stray_ignored: rready=%b bready=%b mem_ready=%b want 0/0/0",
          axi.m_axi_rready, axi.m_axi_bready, mem_ready); end
    end
    stray_r = 0; stray_b = 0;
    @(negedge CLK);
    ar_lat = 0; r_lat = 0; r_val = 32'hA5A5_5A5A;
    run_and_check("tmo_recover", 32'h0000_0020, 32'h0, 4'h0, 1'b0, 32'hA5A5_5A5A, 1'b0);
    checks++; if (r_hs != r0 + 1) begin errors++; $display("FAIL tmo_recover_r: got %0d want 1", r_hs - r0); end
    // write timeout: error flagged, read data register untouched
    aw_lat = -1; w_lat = 0;
    run_and_check("tmo_wr", 32'h3000_0004, 32'h1111_2222, 4'b0001, 1'b0, 32'h0, 1'b1);
    checks++; if (mem_rdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL tmo_wr_rdata: got %h want a5a55a5a", mem_rdata); end
    checks++; if (axi.m_axi_awvalid !== 1'b0 || axi.m_axi_wvalid !== 1'b0) begin
      errors++; $display("FAIL tmo_wr_valids: aw=%b w=%b want 0/0", axi.m_axi_awvalid, axi.m_axi_wvalid); end
  endtask

  task automatic test_back_to_back;
    int a0 = ar_hs;
    ar_lat = 0; r_lat = 1; r_val = 32'h0000_1111;
    run_and_check("b2b_0", 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h0000_1111, 1'b0);
    r_val = 32'h0000_2222;
    run_and_check("b2b_1", 32'h0000_0104, 32'h0, 4'h0, 1'b0, 32'h0000_2222, 1'b0);
    repeat (6) @(negedge CLK);
    checks++; if (ar_hs != a0 + 2) begin errors++; $display("FAIL b2b_ar_count: got %0d want 2", ar_hs - a0); end
    checks++; if (last_araddr !== 32'h0000_0104) begin errors++; $display("FAIL b2b_araddr: got %h want 00000104", last_araddr); end
  endtask

  task automatic test_reset_mid;
    int n = 0, pulses = 0;
    ar_lat = 0; r_lat = 50; r_val = 32'h7777_7777;
    @(negedge CLK);
    mem_addr = 32'h0000_0200; mem_wstrb = 4'h0; mem_instr = 1'b1; mem_valid = 1;
    while (!axi.m_axi_rready && n < 20) begin @(negedge CLK); n++; end
    checks++; if (axi.m_axi_rready !== 1'b1) begin errors++; $display("FAIL rst_mid_reach: rready=%b want 1", axi.m_axi_rready); end
    #1 RSTb = 0;
    #1;
    checks++; if (mem_ready !== 1'b0 || bus_error !== 1'b0 || mem_rdata !== 32'h0 || axi.m_axi_rready !== 1'b0 ||
                  axi.m_axi_arvalid !== 1'b0 || axi.m_axi_araddr !== 32'h0 || axi.m_axi_arprot !== 3'b000) begin
      errors++; $display("FAIL rst_mid_outs: ready=%b err=%b rdata=%h rready=%b arvalid=%b araddr=%h arprot=%b want all 0",
        mem_ready, bus_error, mem_rdata, axi.m_axi_rready, axi.m_axi_arvalid, axi.m_axi_araddr, axi.m_axi_arprot); end
    mem_valid = 0;
    repeat (2) @(negedge CLK);
    RSTb = 1;
    for (int i = 0; i < 10; i++) begin @(negedge CLK); if (mem_ready) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_ready: %0d mem_ready pulses want 0", pulses); end
    r_lat = 0; r_val = 32'h0BEE_F00D;
    run_and_check("rst_after", 32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h0BEE_F00D, 1'b0);
  endtask

  initial begin
    RSTb = 0; mem_valid = 0; mem_instr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(negedge CLK);
    test_reset();
    RSTb = 1;
    @(negedge CLK);
    test_read_rom();
    test_ifetch();
    test_write_scratch();
    test_w_before_aw();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
